// File: rtl/ahb_arbiter2.sv
// Two-master AHB arbiter with address/data muxing toward one slave, round-robin with idle-beat handover.
// Optional master lock support is compiled in with `define AHB_ARB_LOCK_EN.
module ahb_arbiter2 #(
  parameter int ADDR_W      = 36,
  parameter int DATA_W      = 64,
  parameter bit DEFAULT_MST = 1'b0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HBUSREQ0,
  input  logic              HBUSREQ1,
  input  logic              HLOCK0,
  input  logic              HLOCK1,
  input  logic [ADDR_W-1:0] HADDR0,
  input  logic [ADDR_W-1:0] HADDR1,
  input  logic [1:0]        HTRANS0,
  input  logic [1:0]        HTRANS1,
  input  logic              HWRITE0,
  input  logic              HWRITE1,
  input  logic [2:0]        HSIZE0,
  input  logic [2:0]        HSIZE1,
  input  logic [2:0]        HBURST0,
  input  logic [2:0]        HBURST1,
  input  logic [DATA_W-1:0] HWDATA0,
  input  logic [DATA_W-1:0] HWDATA1,
  output logic              HGRANT0,
  output logic              HGRANT1,
  output logic              HMASTER,
  output logic              HMASTLOCK,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP
);

  typedef enum logic [1:0] {
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam state_t STATE_DFLT = DEFAULT_MST ? GNT1 : GNT0;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   down_q, down_d;
  logic   lk_q;
  logic   rearb, req_own, req_oth, winner;

  assign HGRANT0 = state_q[0];
  assign HGRANT1 = state_q[1];
  assign HMASTER = state_q[1];

  assign HADDR  = HMASTER ? HADDR1  : HADDR0;
  assign HTRANS = HMASTER ? HTRANS1 : HTRANS0;
  assign HWRITE = HMASTER ? HWRITE1 : HWRITE0;
  assign HSIZE  = HMASTER ? HSIZE1  : HSIZE0;
  assign HBURST = HMASTER ? HBURST1 : HBURST0;
  assign HSEL   = HTRANS[1];
  assign HWDATA = down_q ? HWDATA1 : HWDATA0;

`ifdef AHB_ARB_LOCK_EN
  logic lk_d;
  logic unused_resp;
  assign unused_resp = ^HRESP;
  assign lk_d        = HREADY ? (HMASTER ? HLOCK1 : HLOCK0) : lk_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) lk_q <= 1'b0;
    else          lk_q <= lk_d;
  end
`else
  logic unused_lock_resp;
  assign unused_lock_resp = ^{HLOCK0, HLOCK1, HRESP};
  assign lk_q             = 1'b0;
`endif

  assign HMASTLOCK = lk_q;

  // Handover only on a ready IDLE beat, so bursts and wait states keep the bus.
  assign rearb   = HREADY && (HTRANS == 2'b00) && !lk_q;
  assign req_own = HMASTER ? HBUSREQ1 : HBUSREQ0;
  assign req_oth = HMASTER ? HBUSREQ0 : HBUSREQ1;
  assign winner  = ~last_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    down_d  = HREADY ? HMASTER : down_q;
    if (rearb) begin
      if (req_own && req_oth) begin
        state_d = winner ? GNT1 : GNT0;
        last_d  = winner;
      end else if (req_oth) begin
        state_d = HMASTER ? GNT0 : GNT1;
      end else if (!req_own) begin
        state_d = STATE_DFLT;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= STATE_DFLT;
      last_q  <= DEFAULT_MST;
      down_q  <= DEFAULT_MST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      down_q  <= down_d;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter2.sv
// Directed bench for ahb_arbiter2: vector table for arbitration/muxing plus burst, reset and lock sequences.
module tb_ahb_arbiter2;
  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [35:0] A0 = 36'h0_0000_0A00;
  localparam logic [35:0] A1 = 36'h0_0000_1000;
  localparam logic [63:0] WD0 = 64'hD0D0_0000_0000_0000;
  localparam logic [63:0] WD1 = 64'hD1D1_1111_1111_1111;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HBUSREQ0, HBUSREQ1, HLOCK0, HLOCK1;
  logic [35:0] HADDR0, HADDR1;
  logic [1:0]  HTRANS0, HTRANS1;
  logic        HWRITE0, HWRITE1;
  logic [2:0]  HSIZE0, HSIZE1, HBURST0, HBURST1;
  logic [63:0] HWDATA0, HWDATA1;
  logic        HGRANT0, HGRANT1, HMASTER, HMASTLOCK, HSEL;
  logic [35:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [63:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  int errors = 0;
  int checks = 0;

  ahb_arbiter2 #(.ADDR_W(36), .DATA_W(64), .DEFAULT_MST(1'b0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HBUSREQ0(HBUSREQ0), .HBUSREQ1(HBUSREQ1), .HLOCK0(HLOCK0), .HLOCK1(HLOCK1),
    .HADDR0(HADDR0), .HADDR1(HADDR1), .HTRANS0(HTRANS0), .HTRANS1(HTRANS1),
    .HWRITE0(HWRITE0), .HWRITE1(HWRITE1), .HSIZE0(HSIZE0), .HSIZE1(HSIZE1),
    .HBURST0(HBURST0), .HBURST1(HBURST1), .HWDATA0(HWDATA0), .HWDATA1(HWDATA1),
    .HGRANT0(HGRANT0), .HGRANT1(HGRANT1), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic       r0, r1;
    logic [1:0] t0, t1;
    logic       rdy;
    logic       em, esel, edn;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic r1, input logic [1:0] t0,
                     input logic [1:0] t1, input logic rdy);
    HBUSREQ0 = r0; HBUSREQ1 = r1; HTRANS0 = t0; HTRANS1 = t1; HREADY = rdy;
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    HLOCK0 = 1'b0; HLOCK1 = 1'b0;
    HADDR0 = A0; HADDR1 = A1; HWDATA0 = WD0; HWDATA1 = WD1;
    drv(1'b0, 1'b0, IDL, IDL, 1'b1);
    nxt();
    nxt();
    HRESETn = 1'b1;
  endtask

  task automatic chk_grant(input string tag, input logic em);
    chk({tag, ".HGRANT0"}, {63'd0, HGRANT0}, {63'd0, ~em});
    chk({tag, ".HGRANT1"}, {63'd0, HGRANT1}, {63'd0, em});
    chk({tag, ".HMASTER"}, {63'd0, HMASTER}, {63'd0, em});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    HWRITE0 = 1'b1; HWRITE1 = 1'b0;
    HSIZE0 = 3'd3;  HSIZE1 = 3'd2;
    HBURST0 = 3'd1; HBURST1 = 3'd0;
    HRESP = 2'b00;

    //           r0    r1    t0   t1   rdy   m     sel   down
    vecs[0]  = '{1'b0, 1'b0, IDL, IDL, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, IDL, NSQ, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, IDL, NSQ, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, IDL, IDL, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, IDL, IDL, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, NSQ, IDL, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, IDL, IDL, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, IDL, NSQ, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, IDL, IDL, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, NSQ, IDL, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, IDL, IDL, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, IDL, IDL, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, IDL, IDL, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, IDL, IDL, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, IDL, IDL, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, IDL, IDL, 1'b1, 1'b1, 1'b0, 1'b0};

    // Table: reset state, handover, round-robin, default return, wait-state hold.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drv(vecs[i].r0, vecs[i].r1, vecs[i].t0, vecs[i].t1, vecs[i].rdy);
      @(negedge HCLK);
      chk_grant(tag, vecs[i].em);
      chk({tag, ".HSEL"},   {63'd0, HSEL}, {63'd0, vecs[i].esel});
      chk({tag, ".HADDR"},  {28'd0, HADDR}, {28'd0, (vecs[i].em ? A1 : A0)});
      chk({tag, ".HTRANS"}, {62'd0, HTRANS}, {62'd0, (vecs[i].em ? vecs[i].t1 : vecs[i].t0)});
      chk({tag, ".HWRITE"}, {63'd0, HWRITE}, {63'd0, ~vecs[i].em});
      chk({tag, ".HSIZE"},  {61'd0, HSIZE}, (vecs[i].em ? 64'd2 : 64'd3));
      chk({tag, ".HBURST"}, {61'd0, HBURST}, (vecs[i].em ? 64'd0 : 64'd1));
      chk({tag, ".HWDATA"}, HWDATA, (vecs[i].edn ? WD1 : WD0));
      chk({tag, ".HMASTLOCK"}, {63'd0, HMASTLOCK}, 64'd0);
      nxt();
    end

    // INCR4 from M0 with two wait states on beat 2 while M1 keeps requesting.
    do_reset();
    begin
      logic [35:0] baddr[8] = '{36'h100, 36'h108, 36'h110, 36'h110, 36'h110, 36'h118, 36'h118, 36'h118};
      logic [1:0]  btr[8]   = '{NSQ, SQ, SQ, SQ, SQ, SQ, IDL, IDL};
      logic        brdy[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [63:0] bwd[8]   = '{64'hA5A5_0000_0000_0000, 64'hA5A5_0000_0000_0001,
                                64'hA5A5_0000_0000_0002, 64'hA5A5_0000_0000_0002,
                                64'hA5A5_0000_0000_0002, 64'hA5A5_0000_0000_0003,
                                64'hA5A5_0000_0000_0004, 64'hA5A5_0000_0000_0004};
      for (int i = 0; i < 8; i++) begin
        string tag;
        tag = $sformatf("burst%0d", i);
        HADDR0 = baddr[i];
        HWDATA0 = bwd[i];
        drv(1'b1, 1'b1, btr[i], (i == 7) ? NSQ : IDL, brdy[i]);
        @(negedge HCLK);
        chk_grant(tag, (i == 7));
        if (i > 0) chk({tag, ".HWDATA"}, HWDATA, bwd[i]);
        if (i < 7) chk({tag, ".HADDR"}, {28'd0, HADDR}, {28'd0, baddr[i]});
        else       chk({tag, ".HADDR"}, {28'd0, HADDR}, {28'd0, A1});
        nxt();
      end
    end

    // Reset in the middle of an M1 burst returns to the default master at once.
    do_reset();
    drv(1'b0, 1'b1, IDL, IDL, 1'b1);
    nxt();
    drv(1'b0, 1'b1, IDL, NSQ, 1'b1);
    @(negedge HCLK);
    chk_grant("rst.pre0", 1'b1);
    nxt();
    drv(1'b0, 1'b1, IDL, SQ, 1'b1);
    @(negedge HCLK);
    chk("rst.pre.HWDATA", HWDATA, WD1);
    HRESETn = 1'b0;
    nxt();
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk_grant("rst.post", 1'b0);
    chk("rst.post.HSEL", {63'd0, HSEL}, 64'd0);
    chk("rst.post.HWDATA", HWDATA, WD0);
    nxt();

    // M0 lock over an IDLE beat while M1 requests.
    do_reset();
    begin
      logic       lr1[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [1:0] lt0[7] = '{IDL, NSQ, IDL, NSQ, IDL, IDL, IDL};
      logic       lh0[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef AHB_ARB_LOCK_EN
      logic       lem[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       lml[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
      logic       lem[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic       lml[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int i = 0; i < 7; i++) begin
        string tag;
        tag = $sformatf("lock%0d", i);
        HLOCK0 = lh0[i];
        drv(1'b1, lr1[i], lt0[i], IDL, 1'b1);
        @(negedge HCLK);
        chk_grant(tag, lem[i]);
        chk({tag, ".HMASTLOCK"}, {63'd0, HMASTLOCK}, {63'd0, lml[i]});
        nxt();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
